hub_bc_sender: RTL and testbench

Broadcast-data sender that sits directly downstream of the hub register block. When the hub asserts `write_trig` (this board's turn in the broadcast sequence), it snapshots `NUM_QUADS` quadlets of this board's status into a local buffer and streams them to the FireWire transmit path as one block-write payload. The destination is this board's slot in every hub memory. It returns `write_trig_reset` to the hub on acceptance, closing the trigger handshake.

---
 rtl/hub_bc_sender_pkg.sv | 22 ++
 rtl/hub_bc_sender_buf.sv | 24 ++
 rtl/hub_bc_sender.sv | 172 +++++++++++++++++
 tb/tb_hub_bc_sender.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub_bc_sender_pkg.sv
// Shared constants and types for the hub broadcast sender: hub address nibble,
// per-board quadlet count and default register-space source base.
package hub_bc_sender_pkg;

    localparam logic [3:0]  ADDR_HUB          = 4'h1;
    localparam int          NUM_BC_READ_QUADS = 29;
    localparam logic [15:0] BC_SRC_BASE       = 16'h0000;
    localparam int          BUF_DEPTH         = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SEND  = 2'd3
    } bc_state_e;

    // This board's slot in every hub memory.
    function automatic logic [15:0] hub_slot_addr(input logic [3:0] board_id);
        return {ADDR_HUB, 3'd0, board_id, 5'd0};
    endfunction

endpackage

// File: rtl/hub_bc_sender_buf.sv
// Snapshot buffer: 32x32 simple dual-port, synchronous write, asynchronous read,
// so the transmit side sees a quadlet in the same cycle its index changes.
module bc_quad_buf
    import hub_bc_sender_pkg::*;
(
    input  logic        sysclk,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data
);

    logic [31:0] mem_q [BUF_DEPTH];

    always_ff @(posedge sysclk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/hub_bc_sender.sv
// Broadcast-data sender: snapshots this board's status quadlets on a hub trigger
// and streams them as one block-write payload to the transmit path.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting for write_trig; quadlet 0 written on acceptance
//   ST_FILL  | one source read per cycle, k = 1..NUM_QUADS-1
//   ST_DRAIN | waiting for outstanding reads to land in the buffer
//   ST_SEND  | presenting buffer[tx_cnt], advancing on tx_valid && tx_ready
module hub_bc_sender
    import hub_bc_sender_pkg::*;
#(
    parameter int          NUM_QUADS = NUM_BC_READ_QUADS,
    parameter logic [15:0] SRC_BASE  = BC_SRC_BASE,
    parameter int          RD_LAT    = 1
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        write_trig,
    output logic        write_trig_reset,
    input  logic [15:0] sequence_num,
    input  logic [3:0]  board_id,
    output logic        src_rreq,
    output logic [15:0] src_raddr,
    input  logic [31:0] src_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_data,
    output logic        tx_first,
    output logic        tx_last,
    output logic [15:0] tx_addr,
    output logic        busy
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_QUADS - 1);

    bc_state_e         state_q, state_d;
    logic [4:0]        rd_cnt_q, rd_cnt_d;
    logic [4:0]        tx_cnt_q, tx_cnt_d;
    logic              wtr_q, wtr_d;
    logic [15:0]       tx_addr_q, tx_addr_d;
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [4:0]        pipe_idx_q [RD_LAT];
    logic [4:0]        pipe_idx_d [RD_LAT];

    logic              accept;
    logic              rd_issue;
    logic              pipe_pending;
    logic              capture;
    logic              buf_we;
    logic [4:0]        buf_waddr;
    logic [31:0]       buf_wdata;
    logic [31:0]       buf_rdata;

    assign accept   = (state_q == ST_IDLE) && write_trig;
    assign rd_issue = (state_q == ST_FILL);
    assign capture  = pipe_vld_q[RD_LAT-1];

    // Read-return pipeline: each stage carries (valid, quadlet index).
    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = rd_issue;
        pipe_idx_d[0] = rd_cnt_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_idx_d[i] = pipe_idx_q[i-1];
        end
    end

    // The last stage is captured this cycle, so only earlier stages block SEND.
    always_comb begin
        pipe_pending = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pipe_pending = pipe_pending | pipe_vld_q[i];
        end
    end

    always_comb begin
        buf_we    = capture || accept;
        buf_waddr = capture ? pipe_idx_q[RD_LAT-1] : 5'd0;
        buf_wdata = capture ? src_rdata : {sequence_num, 16'h0000};
    end

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        tx_cnt_d  = tx_cnt_q;
        wtr_d     = 1'b0;
        tx_addr_d = tx_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (write_trig) begin
                    state_d   = ST_FILL;
                    rd_cnt_d  = 5'd1;
                    wtr_d     = 1'b1;
                    tx_addr_d = hub_slot_addr(board_id);
                end
            end
            ST_FILL: begin
                if (rd_cnt_q == LAST_IDX) begin
                    state_d  = ST_DRAIN;
                    rd_cnt_d = 5'd0;
                end else begin
                    rd_cnt_d = rd_cnt_q + 5'd1;
                end
            end
            ST_DRAIN: begin
                if (!pipe_pending) begin
                    state_d  = ST_SEND;
                    tx_cnt_d = 5'd0;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (tx_cnt_q == LAST_IDX) begin
                        state_d  = ST_IDLE;
                        tx_cnt_d = 5'd0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rd_cnt_q   <= 5'd0;
            tx_cnt_q   <= 5'd0;
            wtr_q      <= 1'b0;
            tx_addr_q  <= 16'd0;
            pipe_vld_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            wtr_q      <= wtr_d;
            tx_addr_q  <= tx_addr_d;
            pipe_vld_q <= pipe_vld_d;
        end
    end

    always_ff @(posedge sysclk) begin
        for (int i = 0; i < RD_LAT; i++) begin
            pipe_idx_q[i] <= pipe_idx_d[i];
        end
    end

    bc_quad_buf u_buf (
        .sysclk  (sysclk),
        .wr_en   (buf_we),
        .wr_addr (buf_waddr),
        .wr_data (buf_wdata),
        .rd_addr (tx_cnt_q),
        .rd_data (buf_rdata)
    );

    assign write_trig_reset = wtr_q;
    assign busy             = (state_q != ST_IDLE);
    assign src_rreq         = rd_issue;
    assign src_raddr        = rd_issue ? (SRC_BASE + 16'(rd_cnt_q) - 16'd1) : 16'd0;
    assign tx_valid         = (state_q == ST_SEND);
    assign tx_data          = tx_valid ? buf_rdata : 32'd0;
    assign tx_first         = tx_valid && (tx_cnt_q == 5'd0);
    assign tx_last          = tx_valid && (tx_cnt_q == LAST_IDX);
    assign tx_addr          = tx_addr_q;

endmodule

// File: tb/tb_hub_bc_sender.sv
// Scoreboard bench for hub_bc_sender: three instances cover the default build
// and the two parameter corners; a negedge monitor checks every handshake.
module tb_hub_bc_sender;

    localparam int NI = 3;

    typedef struct packed {
        logic [1:0]  inst;
        logic        first;
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        trig  [NI];
    logic        wtr   [NI];
    logic [15:0] seqv  [NI];
    logic [3:0]  bid   [NI];
    logic        rreq  [NI];
    logic [15:0] raddr [NI];
    logic [31:0] rdata [NI];
    logic        txv   [NI];
    logic        txr   [NI];
    logic [31:0] txd   [NI];
    logic        txf   [NI];
    logic        txl   [NI];
    logic [15:0] txa   [NI];
    logic        busy  [NI];

    hub_bc_sender #(.NUM_QUADS(29), .SRC_BASE(16'h0000), .RD_LAT(1)) dut_a (
        .sysclk(clk), .reset(reset), .write_trig(trig[0]), .write_trig_reset(wtr[0]),
        .sequence_num(seqv[0]), .board_id(bid[0]), .src_rreq(rreq[0]), .src_raddr(raddr[0]),
        .src_rdata(rdata[0]), .tx_valid(txv[0]), .tx_ready(txr[0]), .tx_data(txd[0]),
        .tx_first(txf[0]), .tx_last(txl[0]), .tx_addr(txa[0]), .busy(busy[0]));

    hub_bc_sender #(.NUM_QUADS(2), .SRC_BASE(16'h0040), .RD_LAT(3)) dut_b (
        .sysclk(clk), .reset(reset), .write_trig(trig[1]), .write_trig_reset(wtr[1]),
        .sequence_num(seqv[1]), .board_id(bid[1]), .src_rreq(rreq[1]), .src_raddr(raddr[1]),
        .src_rdata(rdata[1]), .tx_valid(txv[1]), .tx_ready(txr[1]), .tx_data(txd[1]),
        .tx_first(txf[1]), .tx_last(txl[1]), .tx_addr(txa[1]), .busy(busy[1]));

    hub_bc_sender #(.NUM_QUADS(32), .SRC_BASE(16'h0000), .RD_LAT(1)) dut_c (
        .sysclk(clk), .reset(reset), .write_trig(trig[2]), .write_trig_reset(wtr[2]),
        .sequence_num(seqv[2]), .board_id(bid[2]), .src_rreq(rreq[2]), .src_raddr(raddr[2]),
        .src_rdata(rdata[2]), .tx_valid(txv[2]), .tx_ready(txr[2]), .tx_data(txd[2]),
        .tx_first(txf[2]), .tx_last(txl[2]), .tx_addr(txa[2]), .busy(busy[2]));

    function automatic int nq(input int i);
        case (i)
            0:       return 29;
            1:       return 2;
            default: return 32;
        endcase
    endfunction

    function automatic int lat(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic int base(input int i);
        return (i == 1) ? 32'h40 : 0;
    endfunction

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [95:0] out_vec(input int i);
        return {26'd0, wtr[i], rreq[i], raddr[i], txv[i], txf[i], txl[i], txd[i], txa[i], busy[i]};
    endfunction

    // Source register space: value depends on address and mode at read time.
    logic        src_mode;
    logic [31:0] sp [NI][3];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            sp[i][0] <= (src_mode ? 32'hDEAD0000 : 32'h0000_0100) + {16'h0000, raddr[i]};
            sp[i][1] <= sp[i][0];
            sp[i][2] <= sp[i][1];
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            rdata[i] = sp[i][lat(i)-1];
        end
    end

    // Backpressure driver for instance 0: ready pattern 1,0,0,1 when enabled.
    logic bp_en = 1'b0;
    initial begin
        txr[0] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            txr[0] = bp_en ? !((cyc % 4 == 1) || (cyc % 4 == 2)) : 1'b1;
        end
    end

    exp_t        expq[$];
    logic [15:0] exp_addr  [NI];
    int          hs_cnt    [NI];
    int          wtr_cnt   [NI];
    int          rreq_cnt  [NI];
    logic        stall_prev[NI];
    logic [34:0] hold_v    [NI];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (wtr[i]) wtr_cnt[i]++;
            if (rreq[i]) rreq_cnt[i]++;
            if (stall_prev[i]) chk("stall_hold", {txv[i], txf[i], txl[i], txd[i]}, hold_v[i]);
            stall_prev[i] = txv[i] && !txr[i] && !reset;
            hold_v[i]     = {txv[i], txf[i], txl[i], txd[i]};
            if (txv[i] && txr[i]) begin
                hs_cnt[i]++;
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_quad: inst %0d data %0h with empty scoreboard (cycle %0d)", i, txd[i], cyc);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("quad_inst", i, e.inst);
                    chk("quad_payload", {txf[i], txl[i], txd[i]}, {e.first, e.last, e.data});
                    chk("quad_tx_addr", txa[i], exp_addr[i]);
                end
            end
        end
    end

    task automatic push_pkt(input int i, input logic [15:0] s, input logic mode);
        for (int k = 0; k < nq(i); k++) begin
            exp_t e;
            e.inst  = 2'(i);
            e.first = (k == 0);
            e.last  = (k == nq(i) - 1);
            if (k == 0) e.data = {s, 16'h0000};
            else        e.data = (mode ? 32'hDEAD0000 : 32'h0000_0100) + 32'(base(i) + k - 1);
            expq.push_back(e);
        end
    endtask

    task automatic wait_valid(input int i, output int c);
        c = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (txv[i]) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_vec++; n_err++;
            $display("FAIL wait_valid: inst %0d tx_valid never rose, want within 400 cycles", i);
        end
    endtask

    task automatic wait_last(input int i, output int c);
        c = -1;
        for (int n = 0; n < 400; n++) begin
            if (txv[i] && txr[i] && txl[i]) begin
                c = cyc;
                break;
            end
            @(negedge clk);
        end
        if (c < 0) begin
            n_vec++; n_err++;
            $display("FAIL wait_last: inst %0d no tx_last handshake, want within 400 cycles", i);
        end
    endtask

    task automatic run_pkt(input int i, input logic [15:0] s, input logic [3:0] b,
                           input logic [15:0] ea, input logic mode, input bit timed, input bit flip);
        int t, c, w0, h0, r0;
        w0 = wtr_cnt[i]; h0 = hs_cnt[i]; r0 = rreq_cnt[i];
        @(posedge clk); #1;
        seqv[i] = s; bid[i] = b; trig[i] = 1'b1; t = cyc;
        exp_addr[i] = ea;
        push_pkt(i, s, mode);
        @(negedge clk);
        chk("wtr_at_T", wtr[i], 0);
        @(posedge clk); #1;
        trig[i] = 1'b0;
        @(negedge clk);
        chk("wtr_T1", wtr[i], 1);
        chk("busy_T1", busy[i], 1);
        chk("rreq_T1", rreq[i], 1);
        chk("raddr_T1", raddr[i], base(i));
        wait_valid(i, c);
        chk("first_valid_cyc", c, t + nq(i) + lat(i));
        chk("tx_first", txf[i], 1);
        chk("tx_addr", txa[i], ea);
        if (flip) src_mode = 1'b1;
        wait_last(i, c);
        if (timed) chk("tx_last_cyc", c, t + 2 * nq(i) + lat(i) - 1);
        @(negedge clk);
        chk("busy_fall", busy[i], 0);
        chk("wtr_pulses", wtr_cnt[i] - w0, 1);
        chk("quad_count", hs_cnt[i] - h0, nq(i));
        chk("rreq_count", rreq_cnt[i] - r0, nq(i) - 1);
    endtask

    initial begin
        int t, c, w0, h0;
        reset = 1'b1;
        src_mode = 1'b0;
        for (int i = 0; i < NI; i++) begin
            trig[i] = 1'b0; seqv[i] = 16'd0; bid[i] = 4'd0;
            hs_cnt[i] = 0; wtr_cnt[i] = 0; rreq_cnt[i] = 0;
            stall_prev[i] = 1'b0; hold_v[i] = '0; exp_addr[i] = 16'd0;
        end
        txr[1] = 1'b1;
        txr[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk("reset_outputs", out_vec(i), 0);

        // Single trigger, ready tied high.
        run_pkt(0, 16'hA5C3, 4'd5, 16'h10A0, 1'b0, 1'b1, 1'b0);

        // Backpressure.
        bp_en = 1'b1;
        run_pkt(0, 16'h5A01, 4'd5, 16'h10A0, 1'b0, 1'b0, 1'b0);
        bp_en = 1'b0;

        // Trigger held high through the send: back-to-back packets.
        w0 = wtr_cnt[0]; h0 = hs_cnt[0];
        @(posedge clk); #1;
        seqv[0] = 16'h1234; bid[0] = 4'd2; trig[0] = 1'b1;
        exp_addr[0] = 16'h1040;
        push_pkt(0, 16'h1234, 1'b0);
        push_pkt(0, 16'h1234, 1'b0);
        wait_last(0, c);
        @(negedge clk);
        chk("held_idle_busy", busy[0], 0);
        chk("held_idle_wtr", wtr[0], 0);
        @(negedge clk);
        chk("held_restart_wtr", wtr[0], 1);
        chk("held_restart_busy", busy[0], 1);
        @(posedge clk); #1;
        trig[0] = 1'b0;
        wait_valid(0, c);
        wait_last(0, c);
        @(negedge clk);
        chk("held_busy_fall", busy[0], 0);
        chk("held_wtr_pulses", wtr_cnt[0] - w0, 2);
        chk("held_quad_count", hs_cnt[0] - h0, 58);

        // Snapshot coherence, then a packet that reads the changed source.
        run_pkt(0, 16'hC0DE, 4'd5, 16'h10A0, 1'b0, 1'b1, 1'b1);
        run_pkt(0, 16'hC0DF, 4'd5, 16'h10A0, 1'b1, 1'b1, 1'b0);
        src_mode = 1'b0;

        // Reset during FILL at k=10 with trigger held; reset+trigger gives no pulse.
        @(posedge clk); #1;
        seqv[0] = 16'h0F0F; bid[0] = 4'd3; trig[0] = 1'b1; t = cyc;
        exp_addr[0] = 16'h1060;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("fill_k10_raddr", raddr[0], 9);
        @(negedge clk);
        chk("rst_fill_outputs", out_vec(0), 0);
        @(posedge clk); #1;
        reset = 1'b0; t = cyc;
        push_pkt(0, 16'h0F0F, 1'b0);
        @(negedge clk);
        chk("rst_trig_no_pulse", wtr[0], 0);
        @(posedge clk); #1;
        trig[0] = 1'b0;
        @(negedge clk);
        chk("reaccept_wtr", wtr[0], 1);
        wait_valid(0, c);
        chk("reaccept_first_valid", c, t + 30);
        wait_last(0, c);
        chk("reaccept_last_cyc", c, t + 58);

        // Reset during SEND at quadlet 15.
        @(posedge clk); #1;
        seqv[0] = 16'hBEEF; bid[0] = 4'd5; trig[0] = 1'b1;
        exp_addr[0] = 16'h10A0;
        push_pkt(0, 16'hBEEF, 1'b0);
        @(posedge clk); #1;
        trig[0] = 1'b0;
        wait_valid(0, c);
        repeat (15) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("send_q15_data", txd[0], 32'h0000_010E);
        @(negedge clk);
        chk("rst_send_outputs", out_vec(0), 0);
        expq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        run_pkt(0, 16'h7777, 4'd5, 16'h10A0, 1'b0, 1'b1, 1'b0);

        // Parameter corners.
        run_pkt(1, 16'h7E57, 4'd9, 16'h1120, 1'b0, 1'b1, 1'b0);
        run_pkt(2, 16'h3232, 4'd15, 16'h11E0, 1'b0, 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
